// File: rtl/vga_sync_receiver_if.sv
// Signal bundle between a VGA timing source and vga_sync_receiver.
//   master : the video source side; drives pixel enable, syncs and RGB,
//            observes the recovered coordinates and status.
//   slave  : the receiver; samples the source, reports pixel position,
//            frame start, lock and sync error pulses.
interface vga_sync_receiver_if;
  logic       iPixelEnable;  // one-cycle strobe per pixel
  logic       iHsync;
  logic       iVsync;
  logic [2:0] iRGB;          // {R,G,B}
  logic [9:0] oX;            // active column
  logic [9:0] oY;            // active row
  logic [2:0] oRGB;          // sampled pixel
  logic       oPixelValid;   // pulse, oX/oY/oRGB valid
  logic       oFrameStart;   // pulse with oPixelValid at (0,0)
  logic       oLocked;       // level, timing locked
  logic       oHsyncErr;     // pulse
  logic       oVsyncErr;     // pulse

  modport master (
    output iPixelEnable, iHsync, iVsync, iRGB,
    input  oX, oY, oRGB, oPixelValid, oFrameStart, oLocked, oHsyncErr, oVsyncErr
  );

  modport slave (
    input  iPixelEnable, iHsync, iVsync, iRGB,
    output oX, oY, oRGB, oPixelValid, oFrameStart, oLocked, oHsyncErr, oVsyncErr
  );
endinterface

// File: rtl/vga_sync_receiver.sv
// VGA timing sink: recovers pixel coordinates, frame boundaries and lock
// status from HSYNC/VSYNC/RGB. All processing happens on pixel-enable ticks.
// Ports:
//   Clock  - system clock
//   Reset  - asynchronous, active-high
//   vif    - slave side of vga_sync_receiver_if (syncs/RGB in, coords/status out)
module vga_sync_receiver #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter bit SYNC_POL    = 1'b0,
  parameter int LOCK_FRAMES = 2
) (
  input logic           Clock,
  input logic           Reset,
  vga_sync_receiver_if.slave vif
);
  localparam logic [9:0] CNT_MAX     = 10'h3FF;
  localparam logic [9:0] H_LAST      = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] H_SYNC_LAST = 10'(H_SYNC - 1);
  localparam logic [9:0] HS          = 10'(H_SYNC + H_BP);
  localparam logic [9:0] HE          = 10'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [9:0] V_LAST      = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] V_SYNC_END  = 10'(V_SYNC);
  localparam logic [9:0] VS          = 10'(V_SYNC + V_BP);
  localparam logic [9:0] VE          = 10'(V_SYNC + V_BP + V_ACTIVE - 1);
  localparam int         FW          = $clog2(LOCK_FRAMES + 1);
  localparam logic [FW-1:0] LOCK_N   = FW'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

  state_t        state_q, state_d;
  logic [9:0]    hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [FW-1:0] frm_q, frm_d;
  logic          hs_q, hs_d, vs_q, vs_d;
  logic [9:0]    x_q, x_d, y_q, y_d;
  logic [2:0]    rgb_q, rgb_d;
  logic          pv_q, pv_d, fs_q, fs_d, lock_q, lock_d, herr_q, herr_d, verr_q, verr_d;

  logic tick, hs_on, hs_was, vs_on, vs_was;
  logic h_as, h_de, v_as, v_de, h_bad, v_bad, active;

  assign tick   = vif.iPixelEnable;
  assign hs_on  = (vif.iHsync == SYNC_POL);
  assign hs_was = (hs_q == SYNC_POL);
  assign vs_on  = (vif.iVsync == SYNC_POL);
  assign vs_was = (vs_q == SYNC_POL);
  assign h_as   = hs_on & ~hs_was;
  assign h_de   = ~hs_on & hs_was;
  assign v_as   = vs_on & ~vs_was;
  assign v_de   = ~vs_on & vs_was;

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    vcnt_d  = vcnt_q;
    frm_d   = frm_q;
    hs_d    = hs_q;
    vs_d    = vs_q;
    x_d     = x_q;
    y_d     = y_q;
    rgb_d   = rgb_q;
    lock_d  = lock_q;
    pv_d    = 1'b0;
    fs_d    = 1'b0;
    herr_d  = 1'b0;
    verr_d  = 1'b0;
    h_bad   = 1'b0;
    v_bad   = 1'b0;
    active  = 1'b0;
    if (tick) begin
      hs_d = vif.iHsync;
      vs_d = vif.iVsync;

      if (h_as)                  hcnt_d = '0;
      else if (hcnt_q != CNT_MAX) hcnt_d = hcnt_q + 10'd1;

      if (h_as && vcnt_q != CNT_MAX) vcnt_d = vcnt_q + 10'd1;
      if (v_as)                      vcnt_d = '0;

      // Vsync normally releases on the same tick as the hsync edge that
      // opens line V_SYNC, so the release is checked against the advanced
      // line count; the assert edge is checked against the line just ended.
      h_bad = (h_as && hcnt_q != H_LAST) || (h_de && hcnt_q != H_SYNC_LAST) ||
              (hcnt_d == CNT_MAX && hcnt_q != CNT_MAX);
      v_bad = (v_as && vcnt_q != V_LAST) || (v_de && vcnt_d != V_SYNC_END) ||
              (vcnt_d == CNT_MAX && vcnt_q != CNT_MAX);

      herr_d = (state_q != SEARCH) && h_bad;
      verr_d = (state_q != SEARCH) && v_bad;

      unique case (state_q)
        SEARCH:
          if (v_as) begin
            state_d = ACQUIRE;
            frm_d   = '0;
          end
        ACQUIRE:
          if (herr_d || verr_d) state_d = SEARCH;
          else if (v_as) begin
            frm_d = frm_q + 1'b1;
            if (frm_d == LOCK_N) state_d = LOCKED;
          end
        LOCKED:
          if (herr_d || verr_d) state_d = SEARCH;
        default: state_d = SEARCH;
      endcase

      lock_d = (state_d == LOCKED);

      // Pixel output uses the post-decision state so an error tick emits nothing.
      active = (hcnt_d >= HS) && (hcnt_d <= HE) && (vcnt_d >= VS) && (vcnt_d <= VE);
      if (active && state_d == LOCKED) begin
        pv_d  = 1'b1;
        x_d   = hcnt_d - HS;
        y_d   = vcnt_d - VS;
        rgb_d = vif.iRGB;
        fs_d  = (x_d == '0) && (y_d == '0);
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= SEARCH;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      frm_q   <= '0;
      // Idle sync level, so the first real assert is seen as an edge.
      hs_q    <= ~SYNC_POL;
      vs_q    <= ~SYNC_POL;
      x_q     <= '0;
      y_q     <= '0;
      rgb_q   <= '0;
      pv_q    <= 1'b0;
      fs_q    <= 1'b0;
      lock_q  <= 1'b0;
      herr_q  <= 1'b0;
      verr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      frm_q   <= frm_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      x_q     <= x_d;
      y_q     <= y_d;
      rgb_q   <= rgb_d;
      pv_q    <= pv_d;
      fs_q    <= fs_d;
      lock_q  <= lock_d;
      herr_q  <= herr_d;
      verr_q  <= verr_d;
    end
  end

  assign vif.oX          = x_q;
  assign vif.oY          = y_q;
  assign vif.oRGB        = rgb_q;
  assign vif.oPixelValid = pv_q;
  assign vif.oFrameStart = fs_q;
  assign vif.oLocked     = lock_q;
  assign vif.oHsyncErr   = herr_q;
  assign vif.oVsyncErr   = verr_q;
endmodule

// File: tb/tb_vga_sync_receiver.sv
// Bench for vga_sync_receiver on a reduced raster. A frame generator knows
// its own raster position and which faults it injects; a scenario-level
// model turns that into expected lock, error and pixel outputs per cycle.
module tb_vga_sync_receiver;
  localparam int H_ACT = 8, H_FP = 2, H_SYN = 3, H_BP = 2;
  localparam int V_ACT = 4, V_FP = 1, V_SYN = 2, V_BP = 2;
  localparam int LOCKF = 2;
  localparam int H_T = H_ACT + H_FP + H_SYN + H_BP;
  localparam int HS  = H_SYN + H_BP;
  localparam int V_T = V_ACT + V_FP + V_SYN + V_BP;
  localparam int VS  = V_SYN + V_BP;
  localparam bit POL = 1'b0;

  logic clk = 1'b0;
  logic rst = 1'b1;

  vga_sync_receiver_if vif();

  vga_sync_receiver #(
    .H_ACTIVE(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYN), .H_BP(H_BP),
    .V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYN), .V_BP(V_BP),
    .SYNC_POL(POL), .LOCK_FRAMES(LOCKF)
  ) dut (
    .Clock(clk),
    .Reset(rst),
    .vif  (vif)
  );

  always #5 clk = ~clk;

  int n_chk, n_pass;
  // scenario model
  bit m_synced, m_locked, prev_short;
  int m_clean;
  // expected outputs after the next clock
  bit e_pv, e_fs, e_lock, e_herr, e_verr;
  int e_x, e_y, e_rgb;
  // per-frame tallies: observed and expected
  int npix, nfs, nherr, nverr, fx, fy, lx, ly;
  int e_npix, e_nfs, e_nherr, e_nverr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
  endtask

  task automatic chk_outs();
    chk("pix_valid", 32'(vif.oPixelValid), 32'(e_pv));
    chk("frame_start", 32'(vif.oFrameStart), 32'(e_fs));
    chk("locked", 32'(vif.oLocked), 32'(e_lock));
    chk("hsync_err", 32'(vif.oHsyncErr), 32'(e_herr));
    chk("vsync_err", 32'(vif.oVsyncErr), 32'(e_verr));
    chk("x", 32'(vif.oX), e_x);
    chk("y", 32'(vif.oY), e_y);
    chk("rgb", 32'(vif.oRGB), e_rgb);
  endtask

  // drive at a negedge, let one posedge pass, check at the next negedge
  task automatic cyc(input bit en, input bit hs, input bit vs, input logic [2:0] rgb);
    vif.iPixelEnable = en;
    vif.iHsync       = hs;
    vif.iVsync       = vs;
    vif.iRGB         = rgb;
    @(negedge clk);
    chk_outs();
    if (vif.oPixelValid === 1'b1) begin
      if (npix == 0) begin fx = int'(vif.oX); fy = int'(vif.oY); end
      lx = int'(vif.oX);
      ly = int'(vif.oY);
      npix++;
    end
    if (vif.oFrameStart === 1'b1) nfs++;
    if (vif.oHsyncErr === 1'b1) nherr++;
    if (vif.oVsyncErr === 1'b1) nverr++;
  endtask

  // one pixel tick preceded by 1..3 disabled clocks carrying random garbage
  task automatic tick(input bit hs, input bit vs, input logic [2:0] rgb, input bit fstart,
                      input bit eh, input bit ev, input int ax, input int ay);
    int idle = int'($urandom_range(1, 3));
    for (int i = 0; i < idle; i++) begin
      e_pv = 0; e_fs = 0; e_herr = 0; e_verr = 0;
      cyc(1'b0, 1'($urandom), 1'($urandom), 3'($urandom));
    end
    e_herr = 0; e_verr = 0;
    if (m_synced && (eh || ev)) begin
      e_herr = eh; e_verr = ev;
      m_synced = 0; m_locked = 0;
    end else if (fstart) begin
      if (!m_synced) begin m_synced = 1; m_clean = 0; end
      else begin
        m_clean++;
        if (m_clean >= LOCKF) m_locked = 1;
      end
    end
    if (e_herr) e_nherr++;
    if (e_verr) e_nverr++;
    e_lock = m_locked;
    e_pv   = m_locked && ax >= 0;
    e_fs   = e_pv && ax == 0 && ay == 0;
    if (e_pv) begin e_x = ax; e_y = ay; e_rgb = int'(rgb); e_npix++; end
    if (e_fs) e_nfs++;
    cyc(1'b1, hs, vs, rgb);
  endtask

  task automatic do_reset();
    vif.iPixelEnable = 1'b0;
    #2 rst = 1'b1;
    #1;
    m_synced = 0; m_locked = 0; m_clean = 0;
    e_pv = 0; e_fs = 0; e_lock = 0; e_herr = 0; e_verr = 0;
    e_x = 0; e_y = 0; e_rgb = 0;
    chk_outs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // lines: frame height; short_line: line with a 1-pixel-short hsync;
  // rst_v/rst_h: raster point of an async reset; stuck_line: syncs freeze there
  task automatic gen_frame(input int lines, input int short_line, input int rst_v,
                           input int rst_h, input int stuck_line, input bit xpat);
    bit stop;
    bit act;
    bit hs;
    logic [2:0] rgb;
    stop = 0;
    npix = 0; nfs = 0; nherr = 0; nverr = 0;
    e_npix = 0; e_nfs = 0; e_nherr = 0; e_nverr = 0;
    for (int v = 0; v < lines && !stop; v++) begin
      for (int h = 0; h < H_T && !stop; h++) begin
        if (v == rst_v && h == rst_h) do_reset();
        if (v == stuck_line && h == H_SYN + 1) begin
          for (int k = 1; k <= 1100; k++)
            tick(~POL, ~POL, 3'($urandom), 1'b0, (H_SYN + k) == 1023, 1'b0, -1, -1);
          stop = 1;
        end else begin
          act = h >= HS && h < HS + H_ACT && v >= VS && v < VS + V_ACT;
          rgb = xpat ? 3'(h - HS) : 3'($urandom);
          hs  = (h < ((v == short_line) ? H_SYN - 1 : H_SYN)) ? POL : ~POL;
          tick(hs, (v < V_SYN) ? POL : ~POL, rgb, v == 0 && h == 0,
               v == short_line && h == H_SYN - 1, v == 0 && h == 0 && prev_short,
               act ? h - HS : -1, act ? v - VS : -1);
        end
      end
    end
    prev_short = !stop && lines != V_T;
    chk("frame_pixels", npix, e_npix);
    chk("frame_starts", nfs, e_nfs);
    chk("frame_hsync_errs", nherr, e_nherr);
    chk("frame_vsync_errs", nverr, e_nverr);
    if (e_npix == H_ACT * V_ACT) begin
      chk("first_x", fx, 0);
      chk("first_y", fy, 0);
      chk("last_x", lx, H_ACT - 1);
      chk("last_y", ly, V_ACT - 1);
    end
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    m_synced = 0; m_locked = 0; m_clean = 0; prev_short = 0;
    e_pv = 0; e_fs = 0; e_lock = 0; e_herr = 0; e_verr = 0;
    e_x = 0; e_y = 0; e_rgb = 0;
    npix = 0; nfs = 0; nherr = 0; nverr = 0; fx = 0; fy = 0; lx = 0; ly = 0;
    vif.iPixelEnable = 1'b0;
    vif.iHsync = ~POL;
    vif.iVsync = ~POL;
    vif.iRGB = 3'd0;
    rst = 1'b1;
    @(negedge clk);
    chk_outs();
    rst = 1'b0;

    // acquire and lock: no pixels in frames 1-2, full frame 3
    repeat (3) gen_frame(V_T, -1, -1, -1, -1, 1'b0);
    gen_frame(V_T, -1, -1, -1, -1, 1'b1);
    // short hsync pulse while locked, then relock
    gen_frame(V_T, int'($urandom_range(0, V_T - 1)), -1, -1, -1, 1'b0);
    repeat (3) gen_frame(V_T, -1, -1, -1, -1, 1'b0);
    // one line missing: early vsync edge
    gen_frame(V_T - 1, -1, -1, -1, -1, 1'b0);
    repeat (4) gen_frame(V_T, -1, -1, -1, -1, 1'b0);
    // async reset mid-line while locked
    gen_frame(V_T, -1, int'($urandom_range(VS, VS + V_ACT - 1)),
              int'($urandom_range(HS, H_T - 1)), -1, 1'b0);
    // syncs frozen while acquiring: single saturation error
    gen_frame(V_T, -1, -1, -1, 3, 1'b0);
    repeat (3) gen_frame(V_T, -1, -1, -1, -1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/vga_sync_receiver.md
Name: vga_sync_receiver

Overview:
- Sink end of the VGA timing interface: takes HSYNC/VSYNC/RGB as produced by the VGA controller and recovers pixel coordinates, frame boundaries and lock status.
- Used as an on-chip monitor/capture front end, for example for loopback checking of the video path and for frame capture into RAM.
- Runs on the 50 MHz system clock, qualified by the 25 MHz pixel enable.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, sync asserted level (0 = active-low)
- LOCK_FRAMES, 2, consecutive error-free frames required to declare lock

Ports:
- Clock  in  1  system clock, 50 MHz
- Reset  in  1  asynchronous, active-high
- iPixelEnable  in  1  one-cycle strobe per pixel (every 2nd Clock)
- iHsync  in  1  horizontal sync
- iVsync  in  1  vertical sync
- iRGB  in  3  {R,G,B} pixel data
- oX  out  10  active-area column, 0..H_ACTIVE-1
- oY  out  10  active-area row, 0..V_ACTIVE-1
- oRGB  out  3  sampled pixel
- oPixelValid  out  1  pulse; oX/oY/oRGB valid
- oFrameStart  out  1  pulse coincident with oPixelValid at pixel (0,0)
- oLocked  out  1  level; timing locked
- oHsyncErr  out  1  one-cycle error pulse
- oVsyncErr  out  1  one-cycle error pulse

Behaviour:
- Reset (async): state SEARCH; hcnt=0, vcnt=0, frame counter=0; all outputs 0.
- Derived totals: H_TOTAL = 800, HS = H_SYNC+H_BP = 144; V_TOTAL = 525, VS = V_SYNC+V_BP = 35.
- Sampling and edges:
  - All processing happens only on Clock edges where iPixelEnable=1 (a "tick").
  - Sync inputs are registered on each tick. An edge is detected by comparing with the previous tick's sample.
  - "Assert edge" means a transition to the SYNC_POL level.
- hcnt:
  - Set to 0 on the tick with an hsync assert edge; otherwise +1 per tick.
  - Saturates at 1023.
- vcnt:
  - +1 on each hsync assert edge.
  - Set to 0 on a vsync assert edge. A vsync assert edge wins over a same-tick hsync assert edge.
  - Saturates at 1023.
- Active region: HS <= hcnt <= HS+H_ACTIVE-1 and VS <= vcnt <= VS+V_ACTIVE-1. Within it, x = hcnt-HS and y = vcnt-VS.
- Output timing:
  - oPixelValid pulses 1 Clock after a tick that is in the active region, and only when oLocked=1.
  - oX/oY/oRGB are registered with it and hold their values between pulses.
  - oFrameStart = oPixelValid AND x=0 AND y=0.
- Hsync error (any state other than SEARCH):
  - hsync assert edge while hcnt != H_TOTAL-1, or
  - hsync deassert edge while hcnt != H_SYNC-1, or
  - hcnt reaching 1023.
- Vsync error (any state other than SEARCH):
  - vsync assert edge while vcnt != V_TOTAL-1, or
  - vsync deassert edge while vcnt != V_SYNC, or
  - vcnt reaching 1023.
- Error outputs:
  - Each error produces a single 1-Clock pulse on the matching output.
  - The saturation error fires once, not continuously.
- FSM:
  - SEARCH → ACQUIRE on the first vsync assert edge; frame counter cleared.
  - ACQUIRE: each vsync assert edge with no error since the previous one increments the frame counter.
  - ACQUIRE → LOCKED when the frame counter reaches LOCK_FRAMES; oLocked=1 from the next Clock.
  - ACQUIRE or LOCKED → SEARCH on any error; oLocked=0 on the following Clock; pixel output stops immediately.
  - The vsync assert edge that moves SEARCH→ACQUIRE also restarts vcnt=0.
- iPixelEnable held low: no state change, outputs hold, pulses deassert.
- Reset mid-frame: immediate return to reset values. Lock must be re-acquired from SEARCH.

Test Plan:
- Reference 640x480 generator, 3 frames → oLocked rises after the 2nd frame's vsync assert edge (frame 3 start); frame 3 gives exactly 307200 oPixelValid pulses and one oFrameStart; first pulse oX=0/oY=0, last oX=639/oY=479.
- RGB = x[2:0] pattern in locked frame → each pulse's oRGB equals oX[2:0]; oPixelValid never asserts when iPixelEnable was low the previous Clock.
- Locked, one hsync pulse shortened to 95 pixels → single oHsyncErr pulse, oLocked=0 next Clock, no further oPixelValid; relock after 2 clean frames.
- Locked, frame with 524 lines → one oVsyncErr pulse at the early vsync edge, state SEARCH.
- Syncs stuck deasserted 1100 ticks while in ACQUIRE → exactly one oHsyncErr at hcnt=1023; no second pulse.
- Reset asserted asynchronously mid-line while locked → all outputs 0 without a Clock edge; after release, oLocked stays 0 until 2 clean frames.
